// File: rtl/fire_code_pkg.sv
// fire_code_pkg: shared types and helpers for the Fire code interleaver slice.
//   CW_BUS_W         - width of the codeword bus between encoder and channel
//   fire_n()         - codeword length N = DATA_WIDTH + 2*BURST_LENGTH
//   ilv_bank_state_t - interleaver bank fill state
package fire_code_pkg;

  localparam int unsigned CW_BUS_W = 32;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } ilv_bank_state_t;

  function automatic int unsigned fire_n(input int unsigned data_width,
                                         input int unsigned burst_length);
    return data_width + 2 * burst_length;
  endfunction

endpackage

// File: rtl/fire_ilv_bank.sv
// fire_ilv_bank: one DEPTH x N interleaver bank with its fill state machine.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   wr_en           - write wr_data into the next row
//   wr_data         - row payload
//   rd_done         - the last word of this bank has been read out
//   state           - EMPTY / FILLING / FULL
//   rows            - whole storage matrix, row r at rows[r]
//   wr_last_c       - next write fills the last row
module fire_ilv_bank
  import fire_code_pkg::*;
#(
  parameter int unsigned N     = 14,
  parameter int unsigned DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en,
  input  logic [N-1:0]                wr_data,
  input  logic                        rd_done,
  output ilv_bank_state_t             state,
  output logic [DEPTH-1:0][N-1:0]     rows,
  output logic                        wr_last_c
);

  localparam int unsigned CW = $clog2(DEPTH);

  ilv_bank_state_t           state_q, state_d;
  logic [CW-1:0]             wr_cnt_q, wr_cnt_d;
  logic [DEPTH-1:0][N-1:0]   mem_q, mem_d;
  logic                      wr_ok_c;

  // State and storage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      wr_cnt_q <= '0;
      mem_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      mem_q    <= mem_d;
    end
  end

  // Next state and write path
  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    mem_d    = mem_q;
    wr_ok_c  = wr_en && (state_q != FULL);
    if (wr_ok_c) begin
      mem_d[wr_cnt_q] = wr_data;
      wr_cnt_d        = (wr_cnt_q == CW'(DEPTH - 1)) ? '0 : CW'(wr_cnt_q + 1'b1);
    end
    unique case (state_q)
      EMPTY:   if (wr_ok_c) state_d = FILLING;
      FILLING: if (wr_ok_c && (wr_cnt_q == CW'(DEPTH - 1))) state_d = FULL;
      FULL:    if (rd_done) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Outputs
  always_comb begin
    state     = state_q;
    rows      = mem_q;
    wr_last_c = (wr_cnt_q == CW'(DEPTH - 1));
  end

endmodule

// File: rtl/fire_code_interleaver.sv
// fire_code_interleaver: DEPTH x N block interleaver, rows in, columns out.
// Build option: FIRE_ILV_PINGPONG_EN selects two banks (fill overlaps drain);
// undefined gives a single bank that blocks input while full.
// Ports:
//   clk, rst_n                       - clock, asynchronous active-low reset
//   in_valid/in_ready/in_codeword    - codeword stream from the encoder
//   out_valid/out_ready/out_codeword - interleaved word stream
//   out_sof                          - first word of each output block
module fire_code_interleaver
  import fire_code_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned BURST_LENGTH = 3,
  parameter int unsigned DEPTH        = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CW_BUS_W-1:0] in_codeword,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CW_BUS_W-1:0] out_codeword,
  output logic                out_sof
);

  localparam int unsigned N  = fire_n(DATA_WIDTH, BURST_LENGTH);
  localparam int unsigned RW = $clog2(DEPTH);

  logic                      in_xfer_c, out_xfer_c, rd_last_c;
  logic [RW-1:0]             rd_cnt_q, rd_cnt_d;
  logic [DEPTH-1:0][N-1:0]   rd_rows;
  logic [N-1:0]              col_word [DEPTH];
  logic                      unused_hi;

  assign unused_hi  = ^in_codeword[CW_BUS_W-1:N];
  assign in_xfer_c  = in_valid && in_ready;
  assign out_xfer_c = out_valid && out_ready;
  assign rd_last_c  = (rd_cnt_q == RW'(DEPTH - 1));

`ifdef FIRE_ILV_PINGPONG_EN
  ilv_bank_state_t           bank_state   [2];
  logic [DEPTH-1:0][N-1:0]   bank_rows    [2];
  logic                      bank_wr_last [2];
  logic                      wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;

  for (genvar i = 0; i < 2; i++) begin : g_bank
    fire_ilv_bank #(.N(N), .DEPTH(DEPTH)) u_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (in_xfer_c && (wr_sel_q == 1'(i))),
      .wr_data   (in_codeword[N-1:0]),
      .rd_done   (out_xfer_c && rd_last_c && (rd_sel_q == 1'(i))),
      .state     (bank_state[i]),
      .rows      (bank_rows[i]),
      .wr_last_c (bank_wr_last[i])
    );
  end

  // Bank selects: write side flips when a bank fills, read side when it drains
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
    end else begin
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
    end
  end

  always_comb begin
    wr_sel_d  = wr_sel_q ^ (in_xfer_c && bank_wr_last[wr_sel_q]);
    rd_sel_d  = rd_sel_q ^ (out_xfer_c && rd_last_c);
    in_ready  = (bank_state[wr_sel_q] != FULL);
    out_valid = (bank_state[rd_sel_q] == FULL);
    rd_rows   = bank_rows[rd_sel_q];
  end
`else
  ilv_bank_state_t           bank_state;
  logic                      unused_wr_last;

  fire_ilv_bank #(.N(N), .DEPTH(DEPTH)) u_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (in_xfer_c),
    .wr_data   (in_codeword[N-1:0]),
    .rd_done   (out_xfer_c && rd_last_c),
    .state     (bank_state),
    .rows      (rd_rows),
    .wr_last_c (unused_wr_last)
  );

  always_comb begin
    in_ready  = (bank_state != FULL);
    out_valid = (bank_state == FULL);
  end
`endif

  // Read word counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_cnt_q <= '0;
    else        rd_cnt_q <= rd_cnt_d;
  end

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    if (out_xfer_c) rd_cnt_d = rd_last_c ? '0 : RW'(rd_cnt_q + 1'b1);
  end

  // Column-order mapping: stream position p = w*N + b reads row p%DEPTH, column p/DEPTH
  for (genvar w = 0; w < DEPTH; w++) begin : g_word
    for (genvar b = 0; b < N; b++) begin : g_bit
      localparam int unsigned P = w * N + b;
      assign col_word[w][b] = rd_rows[P % DEPTH][P / DEPTH];
    end
  end

  // Output word is zero whenever nothing valid is presented
  always_comb begin
    out_codeword = '0;
    out_sof      = 1'b0;
    if (out_valid) begin
      out_codeword = CW_BUS_W'(col_word[rd_cnt_q]);
      out_sof      = (rd_cnt_q == '0);
    end
  end

endmodule

// File: tb/tb_fire_code_interleaver.sv
module tb_fire_code_interleaver;

  localparam int unsigned DW    = 8;
  localparam int unsigned BL    = 3;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned N     = DW + 2 * BL;
  localparam int unsigned NW    = DEPTH * N;
`ifdef FIRE_ILV_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_codeword = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_codeword;
  logic        out_sof;

  fire_code_interleaver #(.DATA_WIDTH(DW), .BURST_LENGTH(BL), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_codeword  (in_codeword),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_codeword (out_codeword),
    .out_sof      (out_sof)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w;
    logic        sof;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  logic [N-1:0] in_q[$];
  logic [N-1:0] sent_q[$];
  logic [31:0] got_q[$];
  logic        got_sof_q[$];
  logic        stalled_prev = 1'b0;
  logic [31:0] prev_word = '0;
  logic        last_ix = 1'b0;
  logic [N-1:0] dir_in [DEPTH];
  logic [31:0] dir_exp [DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference interleave: lay row r column c at stream position c*DEPTH+r, cut into N-bit words
  function automatic logic [31:0] ilv_word(input logic [N-1:0] rows [DEPTH], input int w);
    logic        stream [NW];
    logic [31:0] word;
    word = '0;
    for (int r = 0; r < DEPTH; r++)
      for (int c = 0; c < N; c++) stream[c * DEPTH + r] = rows[r][c];
    for (int b = 0; b < N; b++) word[b] = stream[w * N + b];
    return word;
  endfunction

  function automatic logic [N-1:0] deint_row(input logic [31:0] words [DEPTH], input int r);
    logic         stream [NW];
    logic [N-1:0] row;
    for (int w = 0; w < DEPTH; w++)
      for (int b = 0; b < N; b++) stream[w * N + b] = words[w][b];
    for (int c = 0; c < N; c++) row[c] = stream[c * DEPTH + r];
    return row;
  endfunction

  task automatic model_push(input logic [N-1:0] cw);
    logic [N-1:0] rows [DEPTH];
    exp_t e;
    in_q.push_back(cw);
    sent_q.push_back(cw);
    if (in_q.size() == DEPTH) begin
      for (int i = 0; i < DEPTH; i++) rows[i] = in_q[i];
      for (int w = 0; w < DEPTH; w++) begin
        e.w   = ilv_word(rows, w);
        e.sof = (w == 0);
        exp_q.push_back(e);
      end
      in_q.delete();
    end
  endtask

  // One clock: check outputs at the current (negedge) point, record transfers, advance
  task automatic tick();
    logic ix, ox;
    ix = in_valid && in_ready;
    ox = out_valid && out_ready;
    if (out_valid) begin
      chk("exp_available", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        chk("out_word", out_codeword, exp_q[0].w);
        chk("out_sof", 32'(out_sof), 32'(exp_q[0].sof));
      end
      if (stalled_prev) chk("stall_hold", out_codeword, prev_word);
    end else begin
      chk("sof_idle", 32'(out_sof), 32'd0);
    end
    if (ox) begin
      got_q.push_back(out_codeword);
      got_sof_q.push_back(out_sof);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    stalled_prev = out_valid && !out_ready;
    prev_word    = out_codeword;
    if (ix) model_push(in_codeword[N-1:0]);
    last_ix = ix;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_directed(input string tag);
    int idx, guard;
    got_q.delete();
    got_sof_q.delete();
    out_ready = 1'b1;
    idx = 0;
    guard = 0;
    while (idx < DEPTH && guard < 50) begin
      in_valid    = 1'b1;
      in_codeword = 32'(dir_in[idx]);
      if (in_ready) idx++;
      tick();
      guard++;
    end
    in_valid = 1'b0;
    chk({tag, "_fill"}, 32'(idx), 32'(DEPTH));
    chk({tag, "_latency"}, 32'(out_valid), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("%s_in_ready_drain%0d", tag, i), 32'(in_ready), 32'(PP));
      tick();
    end
    chk({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
    chk({tag, "_valid_after"}, 32'(out_valid), 32'd0);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(DEPTH));
    if (got_q.size() == DEPTH)
      for (int i = 0; i < DEPTH; i++) begin
        chk($sformatf("%s_w%0d", tag, i), got_q[i], dir_exp[i]);
        chk($sformatf("%s_sof%0d", tag, i), 32'(got_sof_q[i]), 32'(i == 0));
      end
  endtask

  initial begin
    logic [31:0] words [DEPTH];
    logic [N-1:0] row, err;
    int guard, off, cnt, lo, hi, ticks;

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sof", 32'(out_sof), 32'd0);
    chk("rst_out_codeword", out_codeword, 32'd0);
    rst_n = 1'b1;
    tick();

    // Row 0 all ones
    dir_in  = '{14'h3FFF, 14'h0, 14'h0, 14'h0};
    dir_exp = '{32'h1111, 32'h0444, 32'h1111, 32'h0444};
    run_directed("row0_ones");
    // Single bits at both corners
    dir_in  = '{14'h0, 14'h0001, 14'h0, 14'h0};
    dir_exp = '{32'h0002, 32'h0, 32'h0, 32'h0};
    run_directed("bit_r1c0");
    dir_in  = '{14'h0, 14'h0, 14'h0, 14'h2000};
    dir_exp = '{32'h0, 32'h0, 32'h0, 32'h2000};
    run_directed("bit_r3c13");

    // Randomized traffic with random backpressure, 100 blocks
    got_q.delete();
    got_sof_q.delete();
    sent_q.delete();
    guard = 0;
    while (got_q.size() < 100 * DEPTH && guard < 5000) begin
      if (!in_valid || last_ix) begin
        in_valid    = (sent_q.size() < 100 * DEPTH) && ($urandom_range(0, 3) != 0);
        in_codeword = $urandom;
      end
      out_ready = 1'($urandom_range(0, 1));
      tick();
      guard++;
    end
    in_valid = 1'b0;
    chk("rand_count", 32'(got_q.size()), 32'(100 * DEPTH));
    if (got_q.size() == 100 * DEPTH) begin
      for (int k = 0; k < 100; k++) begin
        for (int w = 0; w < DEPTH; w++) words[w] = got_q[k * DEPTH + w];
        for (int r = 0; r < DEPTH; r++)
          chk($sformatf("roundtrip_b%0d_r%0d", k, r), 32'(deint_row(words, r)),
              32'(sent_q[k * DEPTH + r]));
      end
      // A 12-bit channel burst spreads to at most 3 adjacent bits per codeword
      for (int k = 0; k < 10; k++) begin
        off = $urandom_range(0, NW - 12);
        for (int w = 0; w < DEPTH; w++) words[w] = got_q[k * DEPTH + w];
        for (int p = off; p < off + 12; p++) words[p / N][p % N] = ~words[p / N][p % N];
        for (int r = 0; r < DEPTH; r++) begin
          row = deint_row(words, r);
          err = row ^ sent_q[k * DEPTH + r];
          cnt = 0; lo = N; hi = -1;
          for (int c = 0; c < N; c++)
            if (err[c]) begin
              cnt++;
              if (c < lo) lo = c;
              hi = c;
            end
          chk($sformatf("burst_cnt_b%0d_r%0d", k, r), 32'(cnt <= BL), 32'd1);
          chk($sformatf("burst_span_b%0d_r%0d", k, r), 32'(cnt == 0 || (hi - lo + 1) <= BL), 32'd1);
        end
      end
    end
    out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin tick(); guard++; end
    chk("rand_drained", 32'(exp_q.size()), 32'd0);

`ifdef FIRE_ILV_PINGPONG_EN
    // Back-to-back blocks: 4-cycle fill then one word per cycle, no bubbles
    got_q.delete();
    sent_q.delete();
    out_ready = 1'b1;
    ticks = 0;
    while (got_q.size() < 8 * DEPTH && ticks < 200) begin
      in_valid    = (sent_q.size() < 8 * DEPTH);
      in_codeword = $urandom;
      tick();
      ticks++;
    end
    in_valid = 1'b0;
    chk("pp_b2b_cycles", 32'(ticks), 32'(DEPTH + 8 * DEPTH));
`endif

    // Reset after two of four writes discards the partial block
    in_valid = 1'b1;
    in_codeword = 32'h0000_1234;
    tick();
    in_codeword = 32'h0000_2BCD;
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_sof", 32'(out_sof), 32'd0);
    chk("midrst_out_codeword", out_codeword, 32'd0);
    in_q.delete();
    exp_q.delete();
    stalled_prev = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    dir_in  = '{14'h0, 14'h0, 14'h0, 14'h2000};
    dir_exp = '{32'h0, 32'h0, 32'h0, 32'h2000};
    run_directed("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
